nor_logic_sequencer: RTL and testbench

Multi-cycle logic-operation sequencer that builds the CPU's bitwise logic functions from a single shared 4-bit NOR primitive, `ls7402`. It accepts a WIDTH-bit operand pair and an opcode, then schedules one NOR evaluation per clock over nibble-serial micro-steps. It returns the word result with a start/busy/done handshake. It sits between the instruction decoder's logic-op dispatch and the register-file writeback mux.

---
 rtl/nor_logic_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_nor_logic_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/nor_logic_sequencer.sv
// Bitwise logic unit: every op is built from one shared 4-bit NOR, one NOR per clock, LSB nibble first.
// Latency: done pulses S*NIB+1 cycles after accept (S = 1..5 micro-steps per nibble, chosen by op).
// Backpressure: none; start is sampled only in IDLE, ignored while busy or in DONE, never queued.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst    synchronous active-high reset; aborts any operation in flight
//   i_start  request, sampled only in IDLE
//   i_op     000 NOR, 001 OR, 010 AND, 011 NAND, 100 XOR, 101 XNOR, 110 NOT(a), 111 PASS(a)
//   i_a/i_b  operands, latched on accept (i_b unused by NOT and PASS)
//   o_busy   high for the RUN cycles
//   o_done   one-cycle completion pulse
//   o_y      result register, held until the next completion or reset
//   o_zero   o_y == 0, registered with o_y

module nor_logic_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_y,
  output logic             o_zero
);

  localparam int NIB = WIDTH / 4;
  localparam int NW  = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [2:0] OP_NOR  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [NW-1:0]    r_nib;
  logic [2:0]       r_step;
  logic [3:0]       r_t1, r_t2, r_t3, r_t4;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_y;
  logic             r_zero;

  logic [3:0]       w_an, w_bn;
  logic [3:0]       w_x, w_y, w_nor;
  logic [2:0]       w_steps;
  logic             w_last_step;
  logic             w_last_nib;
  logic [WIDTH-1:0] w_word;

  // Micro-steps per nibble for each opcode.
  function automatic logic [2:0] f_steps(input logic [2:0] op);
    case (op)
      OP_NOR, OP_NOT:   f_steps = 3'd1;
      OP_OR, OP_PASS:   f_steps = 3'd2;
      OP_AND:           f_steps = 3'd3;
      OP_NAND, OP_XNOR: f_steps = 3'd4;
      default:          f_steps = 3'd5;  // XOR
    endcase
  endfunction

  assign w_an        = r_a[{r_nib, 2'b00} +: 4];
  assign w_bn        = r_b[{r_nib, 2'b00} +: 4];
  assign w_steps     = f_steps(r_op);
  assign w_last_step = (r_step == w_steps - 3'd1);
  assign w_last_nib  = (r_nib == NW'(NIB - 1));

  // NOR input selection: the only logic allowed ahead of the primitive.
  always_comb begin
    w_x = w_an;
    w_y = w_bn;
    case (r_op)
      OP_NOR: begin
        w_x = w_an; w_y = w_bn;
      end
      OP_NOT: begin
        w_x = w_an; w_y = w_an;
      end
      OP_OR: begin
        if (r_step == 3'd0) begin w_x = w_an; w_y = w_bn; end
        else                begin w_x = r_t1; w_y = r_t1; end
      end
      OP_PASS: begin
        if (r_step == 3'd0) begin w_x = w_an; w_y = w_an; end
        else                begin w_x = r_t1; w_y = r_t1; end
      end
      OP_AND, OP_NAND: begin
        case (r_step)
          3'd0:    begin w_x = w_an; w_y = w_an; end
          3'd1:    begin w_x = w_bn; w_y = w_bn; end
          3'd2:    begin w_x = r_t1; w_y = r_t2; end
          default: begin w_x = r_t3; w_y = r_t3; end
        endcase
      end
      default: begin  // XOR, XNOR
        case (r_step)
          3'd0:    begin w_x = w_an; w_y = w_bn; end
          3'd1:    begin w_x = w_an; w_y = r_t1; end
          3'd2:    begin w_x = w_bn; w_y = r_t1; end
          3'd3:    begin w_x = r_t2; w_y = r_t3; end
          default: begin w_x = r_t4; w_y = r_t4; end
        endcase
      end
    endcase
  end

  ls7402 u_nor (
    .i_x (w_x),
    .i_y (w_y),
    .o_n (w_nor)
  );

  // Assembled word with the nibble being finished this cycle spliced in.
  always_comb begin
    w_word = r_acc;
    w_word[{r_nib, 2'b00} +: 4] = w_nor;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_RUN;
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (w_last_step && w_last_nib) w_next = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_nib  <= '0;
      r_step <= '0;
      r_t1   <= '0;
      r_t2   <= '0;
      r_t3   <= '0;
      r_t4   <= '0;
      r_acc  <= '0;
      r_y    <= '0;
      r_zero <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op   <= i_op;
            r_a    <= i_a;
            r_b    <= i_b;
            r_nib  <= '0;
            r_step <= '0;
            r_t1   <= '0;
            r_t2   <= '0;
            r_t3   <= '0;
            r_t4   <= '0;
            r_acc  <= '0;
          end
        end
        S_RUN: begin
          if (!w_last_step) begin
            // Non-final step k always produces temp t(k+1).
            r_step <= r_step + 3'd1;
            case (r_step)
              3'd0:    r_t1 <= w_nor;
              3'd1:    r_t2 <= w_nor;
              3'd2:    r_t3 <= w_nor;
              default: r_t4 <= w_nor;
            endcase
          end else begin
            r_acc  <= w_word;
            r_step <= '0;
            r_t1   <= '0;
            r_t2   <= '0;
            r_t3   <= '0;
            r_t4   <= '0;
            if (w_last_nib) begin
              r_nib  <= '0;
              r_y    <= w_word;
              r_zero <= (w_word == '0);
            end else begin
              r_nib <= r_nib + NW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_y    = r_y;
  assign o_zero = r_zero;

endmodule

// Shared 4-bit NOR primitive.
// Latency: combinational.
// Backpressure: none.
module ls7402 (
  input  logic [3:0] i_x,
  input  logic [3:0] i_y,
  output logic [3:0] o_n
);
  assign o_n = ~(i_x | i_y);
endmodule

// File: tb/tb_nor_logic_sequencer.sv
// Directed bench for nor_logic_sequencer with a scoreboard of expected results.
// Latency: checks the done cycle and busy window of every operation.
// Backpressure: exercises ignored start while busy/done and reset mid-operation.

module tb_nor_logic_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, zero;
  logic [W-1:0] y;

  always #5 clk = ~clk;

  nor_logic_sequencer #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_op    (op),
    .i_a     (a),
    .i_b     (b),
    .o_busy  (busy),
    .o_done  (done),
    .o_y     (y),
    .o_zero  (zero)
  );

  typedef struct {
    logic [W-1:0] y;
    logic         zero;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
    case (o)
      3'b000:  model = ~(x | z);
      3'b001:  model = x | z;
      3'b010:  model = x & z;
      3'b011:  model = ~(x & z);
      3'b100:  model = x ^ z;
      3'b101:  model = ~(x ^ z);
      3'b110:  model = ~x;
      default: model = x;
    endcase
  endfunction

  function automatic int steps(input logic [2:0] o);
    case (o)
      3'b000, 3'b110: steps = 1;
      3'b001, 3'b111: steps = 2;
      3'b010:         steps = 3;
      3'b011, 3'b101: steps = 4;
      default:        steps = 5;
    endcase
  endfunction

  // Starts from a point where the next cycle is IDLE; returns 1 ns after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
    exp_t e;
    @(negedge clk);
    op = o; a = x; b = z; start = 1'b1;
    e.y    = model(o, x, z);
    e.zero = (e.y == '0);
    e.lat  = steps(o) * (W / 4) + 1;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int   got;
    e   = sb.pop_front();
    got = -1;
    for (int cyc = 1; cyc <= e.lat + 4; cyc++) begin
      @(negedge clk);
      check({tag, " busy/done"}, {30'd0, busy, done},
            {30'd0, (cyc < e.lat), (cyc == e.lat)});
      if (done) begin
        got = cyc;
        break;
      end
    end
    check({tag, " done cycle"}, got, e.lat);
    check({tag, " y"}, y, e.y);
    check({tag, " zero"}, zero, e.zero);
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
    issue(o, x, z);
    wait_done(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   dones, done_cyc;

    rst = 1'b1; start = 1'b1; op = 3'b100; a = 8'hA5; b = 8'h3C;
    repeat (2) begin
      @(negedge clk);
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset y", y, 8'h00);
      check("reset zero", zero, 1'b1);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("no accept under reset", busy, 1'b0);

    run("NOR 00/03",  3'b000, 8'h00, 8'h03);
    run("AND A6/6F",  3'b010, 8'hA6, 8'h6F);
    run("XOR A5/3C",  3'b100, 8'hA5, 8'h3C);
    run("XNOR A5/3C", 3'b101, 8'hA5, 8'h3C);
    run("NOR FF/0F",  3'b000, 8'hFF, 8'h0F);
    run("OR FF/0F",   3'b001, 8'hFF, 8'h0F);
    run("NAND FF/0F", 3'b011, 8'hFF, 8'h0F);
    run("NOT FF",     3'b110, 8'hFF, 8'h0F);
    run("PASS FF",    3'b111, 8'hFF, 8'h0F);
    run("AND 5A/F0",  3'b010, 8'h5A, 8'hF0);

    // Stray starts at cycle 2 (RUN) and 11 (DONE), operands disturbed while busy.
    issue(3'b100, 8'hA5, 8'h3C);
    e = sb.pop_front();
    dones = 0; done_cyc = -1;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      start = (cyc == 2) || (cyc == 11);
      if (start) begin op = 3'b001; a = 8'h00; b = 8'h00; end
      if (cyc == 5) begin a = 8'hFF; b = 8'hFF; end
      @(negedge clk);
      if (done) begin dones++; done_cyc = cyc; end
      check("ignored start busy", busy, (cyc < e.lat));
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("ignored start done count", dones, 1);
    check("ignored start done cycle", done_cyc, e.lat);
    check("ignored start y", y, e.y);

    // Reset sampled on the edge ending cycle 4 of an XOR.
    issue(3'b100, 8'h0F, 8'h3C);
    void'(sb.pop_front());
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort y", y, 8'h00);
    check("abort zero", zero, 1'b1);
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("abort no done", dones, 0);

    run("OR 12/40", 3'b001, 8'h12, 8'h40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
